// File: rtl/muldiv_ctrl_pkg.sv
// Shared RV32M op encodings, FSM state codes and decode helpers
// for the iterative multiply/divide unit.
package muldiv_ctrl_pkg;

  localparam logic [2:0] F_MUL    = 3'b000;
  localparam logic [2:0] F_MULH   = 3'b001;
  localparam logic [2:0] F_MULHSU = 3'b010;
  localparam logic [2:0] F_MULHU  = 3'b011;
  localparam logic [2:0] F_DIV    = 3'b100;
  localparam logic [2:0] F_DIVU   = 3'b101;
  localparam logic [2:0] F_REM    = 3'b110;
  localparam logic [2:0] F_REMU   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  function automatic logic is_div(input logic [2:0] f);
    return f[2];
  endfunction

  function automatic logic is_rem(input logic [2:0] f);
    return f[2] & f[1];
  endfunction

  function automatic logic sgn_1(input logic [2:0] f);
    return (f == F_MULH) || (f == F_MULHSU) ||
           (f == F_DIV)  || (f == F_REM);
  endfunction

  function automatic logic sgn_2(input logic [2:0] f);
    return (f == F_MULH) || (f == F_DIV) ||
           (f == F_REM);
  endfunction

endpackage

// File: rtl/muldiv_ctrl.sv
// Iterative RV32M unit: 32-step shift-add multiply and
// restoring divide over a 64-bit accumulator.
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] opr_1_i,
  input  logic [31:0] opr_2_i,
  input  logic        flush_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] result_o
);

  state_t      state_q, state_d;
  logic [4:0]  cnt_q;
  logic [63:0] acc_q;
  logic [31:0] opd_q;
  logic [2:0]  op_q;
  logic        neg_q;

  logic        a_neg, b_neg, neg_in;
  logic [31:0] mag_1, mag_2;
  logic        div_z, div_ovf, bypass;
  logic [31:0] byp_res;
  logic        accept;

  assign a_neg  = sgn_1(funct3_i) & opr_1_i[31];
  assign b_neg  = sgn_2(funct3_i) & opr_2_i[31];
  assign mag_1  = a_neg ? -opr_1_i : opr_1_i;
  assign mag_2  = b_neg ? -opr_2_i : opr_2_i;
  // Remainder follows the dividend sign; everything else the xor
  assign neg_in = is_rem(funct3_i) ? a_neg : (a_neg ^ b_neg);

  assign div_z   = is_div(funct3_i) && (opr_2_i == 32'd0);
  assign div_ovf = is_div(funct3_i) && !funct3_i[0] &&
                   (opr_1_i == 32'h8000_0000) &&
                   (opr_2_i == 32'hFFFF_FFFF);
  assign bypass  = div_z | div_ovf;

  always_comb begin
    byp_res = 32'd0;
    if (div_z)
      byp_res = is_rem(funct3_i) ? opr_1_i : 32'hFFFF_FFFF;
    else if (div_ovf)
      byp_res = is_rem(funct3_i) ? 32'd0 : 32'h8000_0000;
  end

  assign accept = (state_q == S_IDLE) & start_i & ~flush_i;

  logic [32:0] mul_sum;
  logic [33:0] div_sub;
  logic [63:0] step;

  always_comb begin
    mul_sum = {1'b0, acc_q[63:32]} +
              (acc_q[0] ? {1'b0, opd_q} : 33'd0);
    div_sub = {1'b0, acc_q[63:31]} - {2'b0, opd_q};
    if (!is_div(op_q))
      step = {mul_sum, acc_q[31:1]};
    else if (!div_sub[33])
      step = {div_sub[31:0], acc_q[30:0], 1'b1};
    else
      step = {acc_q[62:0], 1'b0};
  end

  logic [63:0] prod;
  logic [31:0] quot, remv, fix_res;

  assign prod = neg_q ? -acc_q : acc_q;
  assign quot = neg_q ? -acc_q[31:0] : acc_q[31:0];
  assign remv = neg_q ? -acc_q[63:32] : acc_q[63:32];

  always_comb begin
    fix_res = quot;
    unique case (1'b1)
      op_q == F_MUL:                  fix_res = prod[31:0];
      !op_q[2] && (op_q != F_MUL):    fix_res = prod[63:32];
      op_q[2] && op_q[1]:             fix_res = remv;
      op_q[2] && !op_q[1]:            fix_res = quot;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (start_i) state_d = bypass ? S_DONE : S_CALC;
      S_CALC: if (cnt_q == 5'd31) state_d = S_FIX;
      S_FIX:  state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush_i) state_d = S_IDLE;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= 5'd0;
      acc_q    <= 64'd0;
      opd_q    <= 32'd0;
      op_q     <= 3'd0;
      neg_q    <= 1'b0;
      result_o <= 32'd0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q  <= funct3_i;
        cnt_q <= 5'd0;
        neg_q <= neg_in;
        opd_q <= is_div(funct3_i) ? mag_2 : mag_1;
        acc_q <= {32'd0, is_div(funct3_i) ? mag_1 : mag_2};
        if (bypass) result_o <= byp_res;
      end else if (state_q == S_CALC) begin
        cnt_q <= cnt_q + 5'd1;
        acc_q <= step;
      end else if (state_q == S_FIX && !flush_i) begin
        result_o <= fix_res;
      end
    end
  end

  assign busy_o = (state_q != S_IDLE);
  assign done_o = (state_q == S_DONE) & ~flush_i;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed self-checking bench for muldiv_ctrl: latency,
// results, bypass cases, flush, reset and busy behaviour.
module tb_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] opr_1 = 32'd0;
  logic [31:0] opr_2 = 32'd0;
  logic        flush = 1'b0;
  logic        busy_o, done_o;
  logic [31:0] result_o;

  int total = 0;
  int bad = 0;

  muldiv_ctrl dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .start_i  (start),
    .funct3_i (funct3),
    .opr_1_i  (opr_1),
    .opr_2_i  (opr_2),
    .flush_i  (flush),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .result_o (result_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_op(input string tag,
                       input logic [2:0] f,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       input logic [31:0] exp_r,
                       input int exp_lat);
    int n;
    int busy_lo;
    n = 0;
    busy_lo = 0;
    @(negedge clk);
    funct3 = f; opr_1 = a; opr_2 = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    opr_1 = $urandom;
    opr_2 = $urandom;
    while (!done_o && n < 100) begin
      if (!busy_o) busy_lo++;
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_lat"}, 64'(n), 64'(exp_lat));
    chk({tag, "_res"}, {32'd0, result_o}, {32'd0, exp_r});
    chk({tag, "_busy"}, 64'(busy_lo + (busy_o ? 0 : 1)), 64'd0);
    @(posedge clk); #1;
    chk({tag, "_idle"}, {62'd0, busy_o, done_o}, 64'd0);
  endtask

  initial begin
    int n;
    int seen;
    #2;
    chk("rst_busy", {63'd0, busy_o}, 64'd0);
    chk("rst_done", {63'd0, done_o}, 64'd0);
    chk("rst_res", {32'd0, result_o}, 64'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;

    do_op("mul", 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
    do_op("mulhu", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
          32'hFFFF_FFFE, 33);
    do_op("mulh", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
          32'h0000_0000, 33);
    do_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
          32'hFFFF_FFFF, 33);
    do_op("div", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    do_op("rem", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    do_op("divu", 3'b101, 32'd100, 32'd7, 32'd14, 33);
    do_op("remu", 3'b111, 32'd100, 32'd7, 32'd2, 33);
    do_op("divu_z", 3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, 0);
    do_op("rem_z", 3'b110, 32'd5, 32'd0, 32'd5, 0);
    do_op("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF,
          32'h8000_0000, 0);
    do_op("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF,
          32'd0, 0);

    // flush wins over start while idle
    @(negedge clk);
    funct3 = 3'b000; opr_1 = 32'd9; opr_2 = 32'd9;
    start = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    chk("flush_start", {63'd0, busy_o}, 64'd0);

    // flush mid-DIV: result must keep the previous value (0)
    @(negedge clk);
    funct3 = 3'b100; opr_1 = 32'd1000; opr_2 = 32'd3;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
    end
    chk("flush_busy_pre", {63'd0, busy_o}, 64'd1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_busy", {63'd0, busy_o}, 64'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (done_o) seen++;
      @(posedge clk); #1;
    end
    chk("flush_nodone", 64'(seen), 64'd0);
    chk("flush_res", {32'd0, result_o}, 64'd0);
    do_op("mul_after", 3'b000, 32'd3, 32'd4, 32'd12, 33);

    // start while busy is ignored
    @(negedge clk);
    funct3 = 3'b101; opr_1 = 32'd100; opr_2 = 32'd7;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    funct3 = 3'b000; opr_1 = 32'd3; opr_2 = 32'd3; start = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    start = 1'b0;
    n = 8;
    while (!done_o && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ign_lat", 64'(n), 64'd33);
    chk("ign_res", {32'd0, result_o}, 64'd14);
    @(posedge clk); #1;
    chk("ign_idle", {63'd0, busy_o}, 64'd0);

    // asynchronous reset mid-CALC
    @(negedge clk);
    funct3 = 3'b000; opr_1 = 32'd5; opr_2 = 32'd6; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    rst = 1'b0;
    #1;
    chk("mid_rst_busy", {63'd0, busy_o}, 64'd0);
    chk("mid_rst_done", {63'd0, done_o}, 64'd0);
    chk("mid_rst_res", {32'd0, result_o}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    do_op("post_rst", 3'b000, 32'd5, 32'd6, 32'd30, 33);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
